// File: rtl/sid_bus_write_rx.sv
// sid_bus_write_rx: receives one host register write per strobe pulse.
// The strobe is synchronized and must stay high for MIN_HIGH cycles to be
// accepted. The write is decoded, and then a single registered pulse goes
// to the voice or filter register bank.
module sid_bus_write_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic       wr_en,
  output logic [1:0] wr_voice,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] voice_we,
  output logic       filt_we,
  output logic       busy,
  output logic [7:0] glitch_cnt,
  output logic [7:0] reject_cnt
);

  localparam int CNT_W = (MIN_HIGH < 2) ? 1 : $clog2(MIN_HIGH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    COMMIT   = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [14:0]            cap_q, cap_d;      // {rsvd, voice, addr, data}
  logic                   wr_en_q, wr_en_d;
  logic [1:0]             wr_voice_q, wr_voice_d;
  logic [2:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [2:0]             voice_we_q, voice_we_d;
  logic                   filt_we_q, filt_we_d;
  logic                   busy_q, busy_d;
  logic [7:0]             glitch_q, glitch_d;
  logic [7:0]             reject_q, reject_d;

  logic       s;
  logic [1:0] cap_rsvd;
  logic [1:0] cap_voice;
  logic [2:0] cap_addr;
  logic [7:0] cap_data;

  assign s         = sync_q[SYNC_STAGES-1];
  assign cap_rsvd  = cap_q[14:13];
  assign cap_voice = cap_q[12:11];
  assign cap_addr  = cap_q[10:8];
  assign cap_data  = cap_q[7:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Shift the raw strobe into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ui_in[7]};
  end

  // Next-state logic for strobe qualification, write decode and output registers.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. This means no path leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    wr_en_d    = 1'b0;
    voice_we_d = 3'b000;
    filt_we_d  = 1'b0;
    wr_voice_d = wr_voice_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    glitch_d   = glitch_q;
    reject_d   = reject_q;

    unique case (state_q)
      IDLE: begin
        if (s) begin
          // The initiator holds the bus stable while the strobe is high, so
          // the raw pins are captured here without synchronization.
          cap_d   = {ui_in[6:0], uio_in};
          cnt_d   = CNT_W'(1);
          state_d = (MIN_HIGH == 1) ? COMMIT : QUAL;
        end
      end
      QUAL: begin
        if (!s) begin
          state_d  = IDLE;
          glitch_d = sat_inc(glitch_q);
        end else if (cnt_q == CNT_W'(MIN_HIGH - 1)) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        state_d = WAIT_LOW;
        if (cap_rsvd != 2'd0 || (cap_voice == 2'd3 && cap_addr > 3'd3)) begin
          reject_d = sat_inc(reject_q);
        end else begin
          wr_en_d    = 1'b1;
          wr_voice_d = cap_voice;
          wr_addr_d  = cap_addr;
          wr_data_d  = cap_data;
          filt_we_d  = (cap_voice == 2'd3);
          voice_we_d = (cap_voice == 2'd3) ? 3'b000 : 3'(3'b001 << cap_voice);
        end
      end
      WAIT_LOW: begin
        // A strobe held high yields only one write. Wait here until it drops.
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_voice_q <= 2'd0;
      wr_addr_q  <= 3'd0;
      wr_data_q  <= 8'd0;
      voice_we_q <= 3'd0;
      filt_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      glitch_q   <= 8'd0;
      reject_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from the values before the edge, so the order of statements here does not matter.
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      wr_en_q    <= wr_en_d;
      wr_voice_q <= wr_voice_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      voice_we_q <= voice_we_d;
      filt_we_q  <= filt_we_d;
      busy_q     <= busy_d;
      glitch_q   <= glitch_d;
      reject_q   <= reject_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_voice   = wr_voice_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign voice_we   = voice_we_q;
  assign filt_we    = filt_we_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;
  assign reject_cnt = reject_q;

endmodule

// File: tb/tb_sid_bus_write_rx.sv
// Testbench for sid_bus_write_rx. Directed writes push the expected pulse
// (including its cycle) into a scoreboard queue. A monitor on the falling
// edge pops an entry and compares it whenever wr_en is seen.
module tb_sid_bus_write_rx;

  localparam int LAT = 1 + 2 + 2;  // P0 offset + SYNC_STAGES + MIN_HIGH

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic       wr_en, filt_we, busy;
  logic [1:0] wr_voice;
  logic [2:0] wr_addr, voice_we;
  logic [7:0] wr_data, glitch_cnt, reject_cnt;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] vwe;
    logic       fwe;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  sid_bus_write_rx #(.SYNC_STAGES(2), .MIN_HIGH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uio_in     (uio_in),
    .wr_en      (wr_en),
    .wr_voice   (wr_voice),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .voice_we   (voice_we),
    .filt_we    (filt_we),
    .busy       (busy),
    .glitch_cnt (glitch_cnt),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wr_en", 64'(wr_en), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_voice", 64'(wr_voice), 64'(e.voice));
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
          check("voice_we", 64'(voice_we), 64'(e.vwe));
          check("filt_we", 64'(filt_we), 64'(e.fwe));
        end
      end else begin
        check("we_idle", 64'({voice_we, filt_we}), 64'd0);
      end
    end
  end

  // Raise the strobe with the given fields, hold it, drop it, then idle.
  task automatic do_write(input logic [1:0] rsvd, input logic [1:0] voice,
                          input logic [2:0] addr, input logic [7:0] data,
                          input int hi, input int lo, input bit accept,
                          input logic [2:0] vwe, input logic fwe);
    exp_t e;
    @(negedge clk);
    ui_in  = {1'b1, rsvd, voice, addr};
    uio_in = data;
    if (accept) begin
      e.voice = voice; e.addr = addr; e.data = data;
      e.vwe = vwe; e.fwe = fwe; e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({wr_en, wr_voice, wr_addr, wr_data, voice_we, filt_we,
                                busy, glitch_cnt, reject_cnt}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: voice0 addr0 data D6, 2-clock strobe.
    do_write(2'd0, 2'd0, 3'd0, 8'hD6, 2, 4, 1'b1, 3'b001, 1'b0);

    // 2: 1-clock strobe is a glitch.
    @(negedge clk);
    ui_in = {1'b1, 7'd0}; uio_in = 8'h11;
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_low", 64'(busy), 64'd0);
    check("glitch_cnt_1", 64'(glitch_cnt), 64'd1);
    repeat (2) @(negedge clk);

    // 3: strobe held 100 clocks yields one write.
    do_write(2'd0, 2'd1, 3'd4, 8'h99, 100, 6, 1'b1, 3'b010, 1'b0);

    // 4: filter addr 5 is rejected and the outputs hold. Addr 3 is accepted.
    do_write(2'd0, 2'd3, 3'd5, 8'h77, 2, 6, 1'b0, 3'b000, 1'b0);
    check("reject_cnt_1", 64'(reject_cnt), 64'd1);
    check("hold_after_reject", 64'({wr_voice, wr_addr, wr_data}), 64'({2'd1, 3'd4, 8'h99}));
    do_write(2'd1, 2'd0, 3'd1, 8'h55, 2, 6, 1'b0, 3'b000, 1'b0);
    check("reject_rsvd", 64'(reject_cnt), 64'd2);
    do_write(2'd0, 2'd3, 3'd3, 8'h4F, 2, 6, 1'b1, 3'b000, 1'b1);
    check("glitch_still_1", 64'(glitch_cnt), 64'd1);

    // 5: reset while in QUAL.
    @(negedge clk);
    ui_in = {1'b1, 2'd0, 2'd2, 3'd6}; uio_in = 8'hEE;
    repeat (3) @(negedge clk);
    check("busy_in_qual", 64'(busy), 64'd1);
    rst_n = 1'b0;
    ui_in = 8'd0;
    @(negedge clk);
    check("reset_abort_outputs", 64'({wr_en, wr_voice, wr_addr, wr_data, voice_we, filt_we,
                                      busy, glitch_cnt, reject_cnt}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_write(2'd0, 2'd2, 3'd7, 8'h5A, 2, 4, 1'b1, 3'b100, 1'b0);

    // 6: ten writes at host cadence (2 high, 3 low).
    for (int i = 0; i < 10; i++) begin
      do_write(2'd0, 2'(i % 3), 3'(i % 8), 8'(i), 2, 3, 1'b1,
               3'(3'b001 << (i % 3)), 1'b0);
    end
    repeat (10) @(negedge clk);
    check("cadence_glitch_0", 64'(glitch_cnt), 64'd0);
    check("cadence_reject_0", 64'(reject_cnt), 64'd0);
    check("last_data", 64'(wr_data), 64'h09);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("idle_at_end", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
